// File: rtl/frame_addr_if.sv
// Raster-in / address-out bundle between the display timing source and frame_addr_gen.
// The master drives the raster and scale; the slave returns the address and aligned raster.
interface frame_addr_if;
    logic [1:0]  scale_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [16:0] addr_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [1:0]  scale_out;

    modport master (
        output scale_in, hcount_in, vcount_in,
        input  addr_out, hcount_out, vcount_out, scale_out
    );

    modport slave (
        input  scale_in, hcount_in, vcount_in,
        output addr_out, hcount_out, vcount_out, scale_out
    );
endinterface

// File: rtl/frame_addr_gen.sv
// Display raster to camera frame-buffer address, with 1x / 2x / 8/3x upscaling done by
// per-line and per-frame step counters, plus raster/scale delay matching the BRAM read.
module frame_addr_gen #(
    parameter int FB_WIDTH     = 240,
    parameter int FB_HEIGHT    = 320,
    parameter int BRAM_LATENCY = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    frame_addr_if.slave  fb
);
    localparam int DEPTH = 1 + BRAM_LATENCY;
    localparam int XW    = $clog2(FB_WIDTH);
    localparam int YW    = $clog2(FB_HEIGHT);
    localparam int AW    = 17;

    localparam logic [XW-1:0] X_MAX  = XW'(FB_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(FB_HEIGHT - 1);
    localparam logic [AW-1:0] Y_STEP = AW'(FB_WIDTH);

    function automatic logic [3:0] num_of(input logic [1:0] s);
        case (s)
            2'b01:   return 4'd1;
            2'b10:   return 4'd3;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [3:0] den_of(input logic [1:0] s);
        case (s)
            2'b01:   return 4'd2;
            2'b10:   return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    // Returns {increment, new accumulator}; acc+num never exceeds 10, so 4 bits suffice.
    function automatic logic [4:0] dda_step(input logic [3:0] acc,
                                            input logic [3:0] num,
                                            input logic [3:0] den);
        logic [3:0] t;
        t = acc + num;
        if (t >= den) return {1'b1, t - den};
        else          return {1'b0, t};
    endfunction

    logic [1:0]    r_scale;
    logic [XW-1:0] r_x;
    logic [3:0]    r_xacc;
    logic [YW-1:0] r_y;
    logic [3:0]    r_yacc;
    logic [AW-1:0] r_ybase;
    logic [AW-1:0] r_addr;
    logic [10:0]   r_hcount_pipe [DEPTH];
    logic [9:0]    r_vcount_pipe [DEPTH];
    logic [1:0]    r_scale_pipe  [DEPTH];

    logic          w_start;
    logic [1:0]    w_scale;
    logic [1:0]    w_scale_clean;
    logic [3:0]    w_num;
    logic [3:0]    w_den;
    logic [4:0]    w_xstep;
    logic [4:0]    w_ystep;
    logic [XW-1:0] w_x;
    logic [3:0]    w_xacc;
    logic [YW-1:0] w_y;
    logic [3:0]    w_yacc;
    logic [AW-1:0] w_ybase;

    always_comb begin
        w_start       = (fb.hcount_in == 11'd0) && (fb.vcount_in == 10'd0);
        w_scale       = w_start ? fb.scale_in : r_scale;
        w_scale_clean = (w_scale == 2'b11) ? 2'b00 : w_scale;
        w_num         = num_of(w_scale);
        w_den         = den_of(w_scale);
        w_xstep       = dda_step(r_xacc, w_num, w_den);
        w_ystep       = dda_step(r_yacc, w_num, w_den);

        w_x     = r_x;
        w_xacc  = r_xacc;
        w_y     = r_y;
        w_yacc  = r_yacc;
        w_ybase = r_ybase;

        if (fb.hcount_in == 11'd0) begin
            w_x    = '0;
            w_xacc = '0;
            if (fb.vcount_in == 10'd0) begin
                w_y     = '0;
                w_yacc  = '0;
                w_ybase = '0;
            end else begin
                w_yacc = w_ystep[3:0];
                if (w_ystep[4] && (r_y < Y_MAX)) begin
                    w_y     = r_y + 1'b1;
                    w_ybase = r_ybase + Y_STEP;
                end
            end
        end else begin
            w_xacc = w_xstep[3:0];
            if (w_xstep[4] && (r_x < X_MAX)) w_x = r_x + 1'b1;
        end
    end

    // Stage 0: address register; raster/scale enter the BRAM-matching delay line.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_scale <= '0;
            r_x     <= '0;
            r_xacc  <= '0;
            r_y     <= '0;
            r_yacc  <= '0;
            r_ybase <= '0;
            r_addr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_hcount_pipe[i] <= '0;
                r_vcount_pipe[i] <= '0;
                r_scale_pipe[i]  <= '0;
            end
        end else begin
            r_scale <= w_scale;
            r_x     <= w_x;
            r_xacc  <= w_xacc;
            r_y     <= w_y;
            r_yacc  <= w_yacc;
            r_ybase <= w_ybase;
            r_addr  <= w_ybase + AW'(w_x);
            r_hcount_pipe[0] <= fb.hcount_in;
            r_vcount_pipe[0] <= fb.vcount_in;
            r_scale_pipe[0]  <= w_scale_clean;
            for (int i = 1; i < DEPTH; i++) begin
                r_hcount_pipe[i] <= r_hcount_pipe[i-1];
                r_vcount_pipe[i] <= r_vcount_pipe[i-1];
                r_scale_pipe[i]  <= r_scale_pipe[i-1];
            end
        end
    end

    assign fb.addr_out   = r_addr;
    assign fb.hcount_out = r_hcount_pipe[DEPTH-1];
    assign fb.vcount_out = r_vcount_pipe[DEPTH-1];
    assign fb.scale_out  = r_scale_pipe[DEPTH-1];
endmodule

// File: tb/tb_frame_addr_gen.sv
// Bench for frame_addr_gen: fixed vectors, hand-written corner sequences and a randomized
// raster checked against an arithmetic floor(h*NUM/DEN) address model.
module tb_frame_addr_gen;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    frame_addr_if fb ();

    frame_addr_gen #(
        .FB_WIDTH    (240),
        .FB_HEIGHT   (320),
        .BRAM_LATENCY(2)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .fb    (fb)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int sc;
        int h;
        int v;
        int slen;
        int exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int hh [3];
    int vh [3];
    int sh [3];
    int m_fs    = 0;
    bit m_valid = 1'b0;

    task automatic chk_eq(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_addr(input int h, input int v, input int fs);
        int num, den, x, y;
        num = (fs == 2) ? 3 : 1;
        den = (fs == 1) ? 2 : (fs == 2) ? 8 : 1;
        x = (h * num) / den;
        y = (v * num) / den;
        if (x > 239) x = 239;
        if (y > 319) y = 319;
        return y * 240 + x;
    endfunction

    // One raster cycle; outputs are compared #1 after the capturing edge.
    task automatic cyc(input int h, input int v, input int s, input bit rst);
        int ea;
        rst_in       = rst;
        fb.hcount_in = 11'(h);
        fb.vcount_in = 10'(v);
        fb.scale_in  = 2'(s);
        if (!rst && h == 0 && v == 0) begin
            m_fs    = s;
            m_valid = 1'b1;
        end
        ea = model_addr(h, v, m_fs);
        for (int i = 2; i > 0; i--) begin
            hh[i] = hh[i-1];
            vh[i] = vh[i-1];
            sh[i] = sh[i-1];
        end
        hh[0] = h;
        vh[0] = v;
        sh[0] = (m_fs == 3) ? 0 : m_fs;
        @(posedge clk_in);
        #1;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                hh[i] = 0;
                vh[i] = 0;
                sh[i] = 0;
            end
            m_valid = 1'b0;
            m_fs    = 0;
        end else begin
            if (m_valid) chk_eq("addr_model", int'(fb.addr_out), ea);
            chk_eq("hcount_out_model", int'(fb.hcount_out), hh[2]);
            chk_eq("vcount_out_model", int'(fb.vcount_out), vh[2]);
            chk_eq("scale_out_model", int'(fb.scale_out), sh[2]);
        end
    endtask

    initial begin
        vec_t tbl [6];
        int   seq1 [8];
        int   seq2 [8];
        int   nl, len;

        tbl[0] = '{0, 5,   7,   4, 1685};
        tbl[1] = '{1, 5,   7,   6, 722};
        tbl[2] = '{2, 100, 50,  3, 4357};
        tbl[3] = '{0, 300, 10,  4, 2639};
        tbl[4] = '{0, 300, 400, 2, 76799};
        tbl[5] = '{3, 5,   7,   4, 1685};
        seq1 = '{0, 0, 1, 1, 2, 2, 3, 3};
        seq2 = '{0, 0, 0, 1, 1, 1, 2, 2};
        for (int i = 0; i < 3; i++) begin
            hh[i] = 0;
            vh[i] = 0;
            sh[i] = 0;
        end

        cyc(0, 0, 0, 1'b1);
        cyc(0, 0, 0, 1'b1);
        chk_eq("reset_addr",   int'(fb.addr_out),   0);
        chk_eq("reset_hcount", int'(fb.hcount_out), 0);
        chk_eq("reset_vcount", int'(fb.vcount_out), 0);
        chk_eq("reset_scale",  int'(fb.scale_out),  0);

        for (int i = 0; i < 6; i++) begin
            for (int v = 0; v < tbl[i].v; v++)
                for (int h = 0; h < tbl[i].slen; h++) cyc(h, v, tbl[i].sc, 1'b0);
            for (int h = 0; h <= tbl[i].h; h++) cyc(h, tbl[i].v, tbl[i].sc, 1'b0);
            chk_eq($sformatf("tbl%0d_addr", i), int'(fb.addr_out), tbl[i].exp);
        end

        // Raster delay: h=5,v=7 appears on hcount_out/vcount_out three cycles in.
        for (int v = 0; v < 7; v++)
            for (int h = 0; h < 4; h++) cyc(h, v, 0, 1'b0);
        for (int h = 0; h <= 7; h++) cyc(h, 7, 0, 1'b0);
        chk_eq("delay_hcount", int'(fb.hcount_out), 5);
        chk_eq("delay_vcount", int'(fb.vcount_out), 7);

        for (int h = 0; h < 8; h++) begin
            cyc(h, 0, 1, 1'b0);
            chk_eq($sformatf("seq2x_h%0d", h), int'(fb.addr_out), seq1[h]);
        end
        for (int h = 0; h < 8; h++) begin
            cyc(h, 0, 2, 1'b0);
            chk_eq($sformatf("seq83_h%0d", h), int'(fb.addr_out), seq2[h]);
        end

        // Mid-frame scale change must wait for the next frame start.
        for (int v = 0; v < 105; v++)
            for (int h = 0; h < 4; h++) begin
                cyc(h, v, (v >= 100) ? 2 : 0, 1'b0);
                if (v == 102 && h == 3) chk_eq("midframe_1x", int'(fb.addr_out), 24483);
            end
        cyc(0, 0, 2, 1'b0);
        chk_eq("scale_out_d1", int'(fb.scale_out), 0);
        cyc(1, 0, 2, 1'b0);
        chk_eq("scale_out_d2", int'(fb.scale_out), 0);
        cyc(2, 0, 2, 1'b0);
        chk_eq("scale_out_d3", int'(fb.scale_out), 2);
        for (int h = 3; h < 8; h++) cyc(h, 0, 2, 1'b0);
        for (int v = 1; v < 3; v++)
            for (int h = 0; h < 8; h++) cyc(h, v, 0, 1'b0);
        for (int h = 0; h <= 3; h++) cyc(h, 3, 0, 1'b0);
        chk_eq("newframe_83", int'(fb.addr_out), 241);

        // Reset pulse mid-line, then recovery at the next line start.
        for (int v = 0; v < 3; v++)
            for (int h = 0; h < 8; h++) cyc(h, v, 1, 1'b0);
        for (int h = 0; h < 50; h++) cyc(h, 3, 1, 1'b0);
        cyc(50, 3, 1, 1'b1);
        chk_eq("midrst_addr",   int'(fb.addr_out),   0);
        chk_eq("midrst_hcount", int'(fb.hcount_out), 0);
        chk_eq("midrst_vcount", int'(fb.vcount_out), 0);
        chk_eq("midrst_scale",  int'(fb.scale_out),  0);
        for (int h = 51; h < 60; h++) cyc(h, 3, 1, 1'b0);
        cyc(0, 4, 1, 1'b0);
        chk_eq("postrst_line", int'(fb.addr_out), 240);
        for (int h = 1; h < 6; h++) cyc(h, 4, 1, 1'b0);

        // Random frames: random line lengths, scale_in jittering every cycle.
        for (int f = 0; f < 8; f++) begin
            nl = int'($urandom_range(2, 25));
            for (int v = 0; v < nl; v++) begin
                if ($urandom_range(0, 7) == 0) len = int'($urandom_range(240, 300));
                else                           len = int'($urandom_range(1, 12));
                for (int h = 0; h < len; h++) cyc(h, v, int'($urandom_range(0, 3)), 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
